encoder_read_ctrl: RTL and testbench

Sequencer for one encoder_pwm_read instance.
- Launches position acquisitions periodically, choosing calibration (clear) or acquisition-only (start) requests.
- Schedules periodic recalibration.
- Watchdogs each request against a timeout and recovers a hung reader by pulsing the reader's reset.
- Registers the last good position with a valid strobe for the motor control loop.

---
 rtl/encoder_ctrl_pkg.sv | 10 +
 rtl/encoder_read_ctrl.sv | 148 ++++++++++++++
 tb/tb_encoder_read_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/encoder_ctrl_pkg.sv
// encoder_ctrl_pkg: shared types and constants for the encoder read sequencer.
package encoder_ctrl_pkg;
    localparam int ENC_POS_W = 12;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_RES, RECOVER, WAIT_PER} ctrl_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/encoder_read_ctrl.sv
// encoder_read_ctrl: periodic launcher, recalibration scheduler and watchdog
// for one encoder_pwm_read instance, with a registered last-good position.
module encoder_read_ctrl
    import encoder_ctrl_pkg::*;
#(
    parameter int K_PW      = 16,
    parameter int K_TW      = 20,
    parameter int K_RST_CYC = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    input  logic [K_PW-1:0]      i_period,
    input  logic [7:0]           i_recal_every,
    input  logic [K_TW-1:0]      i_timeout,
    input  logic                 i_force_cal,
    input  logic                 i_fault_clr,
    output logic                 o_rd_start,
    output logic                 o_rd_clear,
    output logic                 o_rd_rst_n,
    input  logic                 i_rd_valid,
    input  logic [ENC_POS_W-1:0] i_rd_pos,
    output logic [ENC_POS_W-1:0] o_pos,
    output logic                 o_pos_valid,
    output logic                 o_busy,
    output logic                 o_fault,
    output logic                 o_overrun,
    output logic [7:0]           o_fault_cnt
);
    localparam int RC_W = (K_RST_CYC > 1) ? $clog2(K_RST_CYC) : 1;

    ctrl_state_t          state_q, state_d;
    logic [K_PW-1:0]      pcnt_q, pcnt_d, per_m1;
    logic [K_TW-1:0]      wd_q, wd_d;
    logic [RC_W-1:0]      rcnt_q, rcnt_d;
    logic                 cal_ok_q, cal_ok_d, cal_pend_q, cal_pend_d;
    logic [7:0]           acq_q, acq_d, fcnt_q, fcnt_d;
    logic                 start_q, start_d, clear_q, clear_d, rd_rst_n_q, rd_rst_n_d;
    logic [ENC_POS_W-1:0] pos_q, pos_d;
    logic                 pos_valid_q, pos_valid_d, busy_q, busy_d;
    logic                 fault_q, fault_d, ovr_q, ovr_d;
    logic                 tick, do_cal, expire, rec_done, fault_set, ovr_set;

    always_comb begin
        per_m1 = (i_period < K_PW'(2)) ? K_PW'(1) : i_period - K_PW'(1);
        tick = pcnt_q == per_m1;
        do_cal = !cal_ok_q || cal_pend_q || (i_recal_every != 8'd0 && acq_q >= i_recal_every);
        expire = i_timeout != '0 && wd_q == i_timeout - K_TW'(1);
        rec_done = rcnt_q == RC_W'(K_RST_CYC - 1);
        ovr_set = tick && (state_q == WAIT_RES || state_q == RECOVER);
        state_d = state_q;
        cal_ok_d = cal_ok_q;
        acq_d = acq_q;
        pos_d = pos_q;
        fcnt_d = fcnt_q;
        start_d = 1'b0;
        clear_d = 1'b0;
        pos_valid_d = 1'b0;
        fault_set = 1'b0;
        case (state_q)
            IDLE: if (i_enable) state_d = LAUNCH;
            LAUNCH: begin
                state_d = WAIT_RES;
                clear_d = do_cal;
                start_d = !do_cal;
                cal_ok_d = 1'b1;
                acq_d = do_cal ? 8'd0 : sat_inc8(acq_q);
            end
            // a result arriving on the expiry cycle takes priority over the timeout
            WAIT_RES: begin
                if (i_rd_valid) begin
                    pos_d = i_rd_pos;
                    pos_valid_d = 1'b1;
                    state_d = i_enable ? WAIT_PER : IDLE;
                end else if (expire) begin
                    fault_set = 1'b1;
                    fcnt_d = sat_inc8(fcnt_q);
                    state_d = RECOVER;
                end
            end
            RECOVER: begin
                cal_ok_d = 1'b0;
                if (rec_done) state_d = i_enable ? WAIT_PER : IDLE;
            end
            WAIT_PER: begin
                if (!i_enable) state_d = IDLE;
                else if (tick) state_d = LAUNCH;
            end
            default: state_d = IDLE;
        endcase
        cal_pend_d = i_force_cal || (cal_pend_q && !(state_q == LAUNCH && do_cal));
        pcnt_d = (state_q == IDLE || tick) ? '0 : pcnt_q + K_PW'(1);
        wd_d = (state_q == WAIT_RES) ? wd_q + K_TW'(1) : '0;
        rcnt_d = (state_q == RECOVER) ? rcnt_q + RC_W'(1) : '0;
        fault_d = fault_set || (fault_q && !i_fault_clr);
        ovr_d = ovr_set || (ovr_q && !i_fault_clr);
        busy_d = state_d == WAIT_RES;
        rd_rst_n_d = state_d != RECOVER;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            pcnt_q <= '0;
            wd_q <= '0;
            rcnt_q <= '0;
            cal_ok_q <= 1'b0;
            cal_pend_q <= 1'b0;
            acq_q <= '0;
            fcnt_q <= '0;
            start_q <= 1'b0;
            clear_q <= 1'b0;
            rd_rst_n_q <= 1'b1;
            pos_q <= '0;
            pos_valid_q <= 1'b0;
            busy_q <= 1'b0;
            fault_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q <= pcnt_d;
            wd_q <= wd_d;
            rcnt_q <= rcnt_d;
            cal_ok_q <= cal_ok_d;
            cal_pend_q <= cal_pend_d;
            acq_q <= acq_d;
            fcnt_q <= fcnt_d;
            start_q <= start_d;
            clear_q <= clear_d;
            rd_rst_n_q <= rd_rst_n_d;
            pos_q <= pos_d;
            pos_valid_q <= pos_valid_d;
            busy_q <= busy_d;
            fault_q <= fault_d;
            ovr_q <= ovr_d;
        end
    end

    assign o_rd_start  = start_q;
    assign o_rd_clear  = clear_q;
    assign o_rd_rst_n  = rd_rst_n_q;
    assign o_pos       = pos_q;
    assign o_pos_valid = pos_valid_q;
    assign o_busy      = busy_q;
    assign o_fault     = fault_q;
    assign o_overrun   = ovr_q;
    assign o_fault_cnt = fcnt_q;
endmodule

// File: tb/tb_encoder_read_ctrl.sv
// tb_encoder_read_ctrl: directed scenarios plus random runs against a
// timestamp-based model of the sequencer, with a simple reader stand-in.
module tb_encoder_read_ctrl;
    localparam int K_RST = 2;

    logic        i_clk = 1'b0, i_rst_n = 1'b0, i_enable = 1'b0;
    logic        i_force_cal = 1'b0, i_fault_clr = 1'b0, i_rd_valid = 1'b0;
    logic [15:0] i_period = '0;
    logic [7:0]  i_recal_every = '0;
    logic [19:0] i_timeout = '0;
    logic [11:0] i_rd_pos = '0;
    logic        o_rd_start, o_rd_clear, o_rd_rst_n, o_pos_valid, o_busy, o_fault, o_overrun;
    logic [11:0] o_pos;
    logic [7:0]  o_fault_cnt;

    always #5 i_clk = ~i_clk;

    encoder_read_ctrl #(.K_PW(16), .K_TW(20), .K_RST_CYC(K_RST)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_period(i_period),
        .i_recal_every(i_recal_every), .i_timeout(i_timeout), .i_force_cal(i_force_cal),
        .i_fault_clr(i_fault_clr), .o_rd_start(o_rd_start), .o_rd_clear(o_rd_clear),
        .o_rd_rst_n(o_rd_rst_n), .i_rd_valid(i_rd_valid), .i_rd_pos(i_rd_pos), .o_pos(o_pos),
        .o_pos_valid(o_pos_valid), .o_busy(o_busy), .o_fault(o_fault), .o_overrun(o_overrun),
        .o_fault_cnt(o_fault_cnt)
    );

    int cyc, n_chk, n_err;
    bit en, force_p, fclr_p, fix_en;
    int per, recal, tmo, lat, spur;
    logic [11:0] fix_pos;
    int ans_t, first_fault, n_rst_low;
    int req_t[$];
    bit req_k[$];
    int pv_t[$];
    logic [11:0] pv_p[$];

    // model: request timing is tracked as absolute cycle stamps, not counters
    typedef enum {PH_IDLE, PH_LAUNCH, PH_BUSY, PH_REC, PH_WAIT} phase_t;
    phase_t ph;
    int launch_t, fault_t, acq;
    bit cal_ok, pend;
    logic e_start, e_clear, e_rstn, e_pv, e_busy, e_fault, e_ovr;
    logic [11:0] e_pos;
    logic [7:0] e_fcnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic compare();
        chk("rd_start", o_rd_start, e_start);
        chk("rd_clear", o_rd_clear, e_clear);
        chk("rd_rst_n", o_rd_rst_n, e_rstn);
        chk("pos_valid", o_pos_valid, e_pv);
        chk("pos", o_pos, e_pos);
        chk("busy", o_busy, e_busy);
        chk("fault", o_fault, e_fault);
        chk("overrun", o_overrun, e_ovr);
        chk("fault_cnt", o_fault_cnt, e_fcnt);
    endtask

    task automatic step();
        int p;
        bit tick, fset, oset;
        p = (i_period < 2) ? 2 : int'(i_period);
        tick = ((cyc - launch_t) % p) == p - 1;
        fset = 0;
        oset = 0;
        e_start = 0;
        e_clear = 0;
        e_pv = 0;
        case (ph)
            PH_IDLE: if (i_enable) begin ph = PH_LAUNCH; launch_t = cyc + 1; end
            PH_LAUNCH: begin
                if (!cal_ok || pend || (i_recal_every != 0 && acq >= int'(i_recal_every))) begin
                    e_clear = 1; cal_ok = 1; pend = 0; acq = 0;
                end else begin
                    e_start = 1;
                    if (acq < 255) acq++;
                end
                ph = PH_BUSY;
            end
            PH_BUSY: begin
                oset = tick;
                if (i_rd_valid) begin
                    e_pos = i_rd_pos; e_pv = 1; ph = i_enable ? PH_WAIT : PH_IDLE;
                end else if (i_timeout != 0 && cyc - launch_t == int'(i_timeout)) begin
                    fset = 1; fault_t = cyc; ph = PH_REC;
                    if (e_fcnt != 8'hFF) e_fcnt++;
                end
            end
            PH_REC: begin
                oset = tick;
                cal_ok = 0;
                if (cyc - fault_t == K_RST) ph = i_enable ? PH_WAIT : PH_IDLE;
            end
            default: begin
                if (!i_enable) ph = PH_IDLE;
                else if (tick) begin ph = PH_LAUNCH; launch_t = cyc + 1; end
            end
        endcase
        if (i_force_cal) pend = 1;
        e_fault = fset | (e_fault & !i_fault_clr);
        e_ovr = oset | (e_ovr & !i_fault_clr);
        e_busy = ph == PH_BUSY;
        e_rstn = ph != PH_REC;
    endtask

    task automatic apply();
        if (!o_rd_rst_n) ans_t = -1;
        else if (o_rd_start || o_rd_clear) ans_t = (lat == 0) ? -1 : cyc + lat;
        if (o_rd_start || o_rd_clear) begin req_t.push_back(cyc); req_k.push_back(o_rd_clear); end
        if (o_pos_valid) begin pv_t.push_back(cyc); pv_p.push_back(o_pos); end
        if (!o_rd_rst_n) n_rst_low++;
        if (o_fault && first_fault < 0) first_fault = cyc;
        i_rd_valid = (cyc == ans_t) || (int'($urandom_range(99)) < spur);
        i_rd_pos = fix_en ? fix_pos : 12'($urandom);
        i_enable = en;
        i_period = 16'(per);
        i_recal_every = 8'(recal);
        i_timeout = 20'(tmo);
        i_force_cal = force_p;
        i_fault_clr = fclr_p;
        step();
        force_p = 0;
        fclr_p = 0;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge i_clk);
            compare();
            apply();
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 0;
        en = 0; force_p = 0; fclr_p = 0; fix_en = 0; spur = 0;
        i_enable = 0; i_force_cal = 0; i_fault_clr = 0; i_rd_valid = 0;
        repeat (2) @(negedge i_clk);
        chk("rst_rd_rst_n", o_rd_rst_n, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_fault_cnt", o_fault_cnt, 0);
        chk("rst_pos", o_pos, 0);
        i_rst_n = 1;
        ph = PH_IDLE; cal_ok = 0; pend = 0; acq = 0; launch_t = 0; fault_t = 0;
        e_start = 0; e_clear = 0; e_rstn = 1; e_pv = 0; e_busy = 0;
        e_fault = 0; e_ovr = 0; e_pos = '0; e_fcnt = '0;
        ans_t = -1; first_fault = -1; n_rst_low = 0;
        req_t.delete(); req_k.delete(); pv_t.delete(); pv_p.delete();
        apply();
    endtask

    initial begin
        cyc = 0; n_chk = 0; n_err = 0;
        per = 100; recal = 0; tmo = 0; lat = 20; fix_pos = 12'h3A7;
        // basic periodic acquisition
        do_reset();
        fix_en = 1; en = 1;
        run(320);
        chk("s1_req_count", req_t.size() >= 3, 1);
        chk("s1_first_clear", req_k[0], 1);
        chk("s1_second_start", req_k[1], 0);
        chk("s1_third_start", req_k[2], 0);
        chk("s1_gap01", req_t[1] - req_t[0], 100);
        chk("s1_gap12", req_t[2] - req_t[1], 100);
        chk("s1_pv_lat", pv_t[0] - req_t[0], 21);
        chk("s1_pos", pv_p[0], 12'h3A7);
        // recalibration schedule and forced calibration
        per = 40; recal = 3; lat = 10;
        do_reset();
        en = 1;
        run(215);
        force_p = 1;
        run(61);
        chk("s2_req_count", req_t.size(), 7);
        chk("s2_pattern", {req_k[0], req_k[1], req_k[2], req_k[3], req_k[4], req_k[5], req_k[6]}, 7'b1000101);
        // hung reader
        per = 100; recal = 0; tmo = 50; lat = 0;
        do_reset();
        en = 1;
        run(130);
        chk("s3_fault_delay", first_fault - req_t[0], 50);
        chk("s3_rst_low_cycles", n_rst_low, 2);
        chk("s3_second_clear", req_k[1], 1);
        chk("s3_gap", req_t[1] - req_t[0], 100);
        fclr_p = 1;
        run(2);
        chk("s3_fault_cleared", o_fault, 0);
        chk("s3_fault_cnt_kept", o_fault_cnt, 1);
        // overrun
        per = 10; tmo = 0; lat = 25;
        do_reset();
        en = 1;
        run(40);
        chk("s4_overrun", o_overrun, 1);
        chk("s4_gap", req_t[1] - req_t[0], 30);
        chk("s4_pv_lat", pv_t[0] - req_t[0], 26);
        // result on the expiry cycle
        per = 100; tmo = 30; lat = 29;
        do_reset();
        en = 1;
        run(80);
        chk("s5_no_fault", o_fault, 0);
        chk("s5_no_fault_cnt", o_fault_cnt, 0);
        chk("s5_one_result", pv_t.size(), 1);
        // disable mid-request, then re-enable
        per = 60; tmo = 0; lat = 20;
        do_reset();
        en = 1;
        run(10);
        en = 0;
        run(90);
        chk("s6_one_req", req_t.size(), 1);
        chk("s6_one_result", pv_t.size(), 1);
        chk("s6_idle", o_busy, 0);
        en = 1;
        run(10);
        chk("s6_req_again", req_t.size(), 2);
        chk("s6_restart_is_start", req_k[1], 0);
        // randomized operation
        do_reset();
        for (int s = 0; s < 25; s++) begin
            en = 0;
            run(60);
            if (ph == PH_IDLE) begin
                per = $urandom_range(0, 40);
                recal = $urandom_range(0, 4);
                tmo = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(5, 60);
                lat = (tmo == 0) ? $urandom_range(1, 50) : $urandom_range(0, tmo + 3);
            end
            spur = 2;
            en = 1;
            for (int k = 0; k < 300; k++) begin
                force_p = $urandom_range(99) < 2;
                fclr_p = $urandom_range(99) < 3;
                if ($urandom_range(199) == 0) en = !en;
                run(1);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
